quad_decoder: RTL
=================

Name: quad_decoder

Overview:
Receive-side counterpart of the two-phase toggle generator. It accepts two phase-shifted square waves (channel A leads channel B for forward motion), synchronises and glitch-filters them, and decodes each Gray-code edge into a signed step. It maintains a wrapping position count, flags illegal transitions, and measures the clock-cycle interval between consecutive valid steps, which gives downstream logic a speed readout.

Parameters:
CNT_W, 16, width of position counter (two's-complement, wraps)
FILT_LEN, 4, consecutive stable cycles required before a filtered level changes (>=1)
PER_W, 19, width of step-period counter/output (matches refresh counter width)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
a_in  in  1  channel A, asynchronous to clk
b_in  in  1  channel B, asynchronous to clk
clr  in  1  synchronous clear of pos and err_flag
pos  out  CNT_W  position count
dir  out  1  direction of last valid step (1 = forward)
step  out  1  one-cycle pulse per valid step
err  out  1  one-cycle pulse on illegal transition
err_flag  out  1  sticky illegal-transition flag
period  out  PER_W  cycles between last two valid steps
period_vld  out  1  one-cycle pulse when period updates

Behaviour:
- Reset (rst=0, async): all outputs 0, synchronisers 0, filter counters 0, FSM=INIT, period counter 0.
- Sync: each input passes through its own 2-flop synchroniser (s1, s2).
- Filter (per channel): an independent counter increments on each edge where s2 != filtered level, and clears on any edge where s2 == filtered. The filtered level takes the s2 value on the FILT_LEN-th consecutive differing edge. Pulses shorter than FILT_LEN cycles at s2 are rejected.
- Latency: from the first clk edge that captures a new input level, the filtered level updates at edge 2+FILT_LEN, and step/pos/dir update at edge 3+FILT_LEN.
- FSM INIT: after reset, wait until s2 of both channels has been stable for FILT_LEN cycles. Then load the filtered {A,B} from s2 with no step, and go to TRACK.
- FSM TRACK: compare the registered previous {A,B} with the current filtered {A,B} each cycle.
  - Forward sequence 00->10->11->01->00: pos+1, dir=1, step=1.
  - Reverse sequence 00->01->11->10->00: pos-1, dir=0, step=1.
  - Both bits changed in the same cycle: err=1, err_flag<=1, pos and dir unchanged, no step. The new {A,B} is still adopted as the previous state.
  - No change: no pulses.
- pos wraps modulo 2^CNT_W: 0xFFFF+1 -> 0x0000, and 0x0000-1 -> 0xFFFF.
- clr=1: pos<=0 and err_flag<=0. If a step or error coincides with clr, clr wins for pos and err_flag, but the step/err pulses and dir still update. The period logic is unaffected by clr.
- Period counter: increments every cycle and saturates at 2^PER_W-1.
  - On each valid step it restarts at 1 and period<=counter value (the elapsed cycles).
  - period_vld pulses only if at least one prior valid step has occurred since reset. The first step after reset loads nothing.
  - Error transitions do not affect the period logic.
- dir holds its value between steps. err_flag holds until clr or reset.
- Reset mid-operation forces INIT immediately and discards pending filter counts.

Test Plan:
- Reset with A=B=0, hold 10 cycles, then apply forward sequence 10,11,01,00 with each level held 20 cycles -> 4 step pulses, pos=4, dir=1, no err. The first step lands exactly 7 edges after A rises (FILT_LEN=4).
- From pos=0, apply reverse sequence 01,11,10,00 -> pos=0xFFFC, dir=0; 3-cycle glitch on A in between -> no step, pos unchanged.
- Force {A,B} 00->11 in one cycle -> err pulse 1 cycle, err_flag=1, pos unchanged. Then clr=1 for 1 cycle -> err_flag=0, pos=0.
- Forward steps spaced 100 cycles apart -> first step gives no period_vld; subsequent steps give period=100 with a period_vld pulse each. Stop for more than 2^19 cycles, then step -> period=0x7FFFF.
- Release reset with A=1, B=1 stable -> INIT loads 11, no step, no err. Then B->0 gives 11->10, a reverse step: pos=0xFFFF.
- Assert rst mid-sequence with a filter count pending -> all outputs 0 immediately. After release, INIT relearns the levels and no spurious step occurs.

Source files
------------

// File: rtl/quad_decoder.sv
//-----------------------------------------------------------------------------
// quad_decoder
//
// Quadrature receiver. Two phase-shifted square waves (A leads B for forward
// motion) are synchronised into the clk domain, glitch-filtered, and decoded
// one Gray-code edge at a time into signed steps. The block keeps a wrapping
// position count, flags illegal (double-bit) transitions, and measures the
// number of clk cycles between consecutive valid steps as a speed readout.
//
// Parameters
//   CNT_W     width of the two's-complement position counter (wraps)
//   FILT_LEN  consecutive stable cycles needed before a filtered level moves
//   PER_W     width of the step-period counter and period output
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active low
//   a_in, b_in  quadrature channels, asynchronous to clk
//   clr         synchronous clear of pos and err_flag
//   pos         position count
//   dir         direction of the last valid step (1 = forward)
//   step        one-cycle pulse per valid step
//   err         one-cycle pulse per illegal transition
//   err_flag    sticky illegal-transition flag
//   period      cycles between the last two valid steps
//   period_vld  one-cycle pulse when period is updated
//-----------------------------------------------------------------------------
module quad_decoder #(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 4,
    parameter int PER_W    = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clr,
    output logic [CNT_W-1:0] pos,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic             err_flag,
    output logic [PER_W-1:0] period,
    output logic             period_vld
);

    // Filter and stability counters only ever need to reach FILT_LEN-1:
    // the FILT_LEN-th qualifying edge acts on the value before it is stored.
    localparam int               FCW     = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FCW-1:0]   LEN_M1  = FCW'(FILT_LEN - 1);
    localparam logic [PER_W-1:0] PER_MAX = '1;

    typedef enum logic {
        INIT,
        TRACK
    } state_t;

    // Channel vectors are packed as {A, B}: bit 1 is A, bit 0 is B.
    logic [1:0]            sync1_q;
    logic [1:0]            sync2_q;
    logic [1:0]            fltLvl_q,  fltLvl_d;
    logic [1:0][FCW-1:0]   fltCnt_q,  fltCnt_d;
    logic [FCW-1:0]        stabCnt_q, stabCnt_d;
    state_t                state_q,   state_d;
    logic [1:0]            prevAb_q,  prevAb_d;
    logic [CNT_W-1:0]      pos_q,     pos_d;
    logic                  dir_q,     dir_d;
    logic                  step_q,    step_d;
    logic                  err_q,     err_d;
    logic                  errFlag_q, errFlag_d;
    logic [PER_W-1:0]      perCnt_q,  perCnt_d;
    logic [PER_W-1:0]      period_q,  period_d;
    logic                  perVld_q,  perVld_d;
    logic                  seenStep_q, seenStep_d;
    logic                  initDone;

    // INIT ends once the synchronised inputs have held one value for
    // FILT_LEN cycles; that value is then adopted without producing a step.
    assign initDone = (state_q == INIT) && (stabCnt_q == LEN_M1);

    // Two-flop synchronisers, one per channel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {a_in, b_in};
            sync2_q <= sync1_q;
        end
    end

    // Stability counter used only while in INIT. It tracks how long sync2
    // has held its current value (count of 0 means "just changed").
    always_comb begin
        stabCnt_d = '0;
        if (state_q == INIT) begin
            if (sync1_q == sync2_q) begin
                stabCnt_d = (stabCnt_q == LEN_M1) ? stabCnt_q : stabCnt_q + 1'b1;
            end
        end
    end

    // Per-channel glitch filter. A channel's counter advances while sync2
    // disagrees with the filtered level and drops to zero as soon as they
    // agree, so only runs of FILT_LEN disagreeing cycles move the level.
    // In INIT the counters are held at zero and the level is loaded
    // directly from sync2 on the exit cycle.
    always_comb begin
        fltLvl_d = fltLvl_q;
        fltCnt_d = '0;
        if (state_q == INIT) begin
            if (initDone) begin
                fltLvl_d = sync2_q;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (sync2_q[ch] != fltLvl_q[ch]) begin
                    if (fltCnt_q[ch] == LEN_M1) begin
                        fltLvl_d[ch] = sync2_q[ch];
                    end else begin
                        fltCnt_d[ch] = fltCnt_q[ch] + 1'b1;
                    end
                end
            end
        end
    end

    // Decoder FSM. In TRACK the previous filtered {A,B} is compared with the
    // current one; a single-bit change is a step, a double-bit change is an
    // error that still updates the reference state. clr overrides pos and
    // err_flag but leaves the pulses and dir alone.
    always_comb begin
        state_d   = state_q;
        prevAb_d  = prevAb_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        err_d     = 1'b0;
        errFlag_d = errFlag_q;

        unique case (state_q)
            INIT: begin
                if (initDone) begin
                    state_d  = TRACK;
                    prevAb_d = sync2_q;
                end
            end
            TRACK: begin
                prevAb_d = fltLvl_q;
                case ({prevAb_q, fltLvl_q})
                    4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
                        pos_d  = pos_q + 1'b1;
                        dir_d  = 1'b1;
                        step_d = 1'b1;
                    end
                    4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
                        pos_d  = pos_q - 1'b1;
                        dir_d  = 1'b0;
                        step_d = 1'b1;
                    end
                    4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: begin
                        err_d     = 1'b1;
                        errFlag_d = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            default: begin
                state_d = INIT;
            end
        endcase

        if (clr) begin
            pos_d     = '0;
            errFlag_d = 1'b0;
        end
    end

    // Step-period measurement. The free-running counter saturates; on a
    // valid step it restarts at 1 and its old value becomes the period.
    // The very first step after reset has no earlier step to measure from,
    // so it only arms the logic.
    always_comb begin
        perCnt_d   = (perCnt_q == PER_MAX) ? perCnt_q : perCnt_q + 1'b1;
        period_d   = period_q;
        perVld_d   = 1'b0;
        seenStep_d = seenStep_q;
        if (step_d) begin
            perCnt_d   = PER_W'(1);
            seenStep_d = 1'b1;
            if (seenStep_q) begin
                period_d = perCnt_q;
                perVld_d = 1'b1;
            end
        end
    end

    // State registers for filter, FSM, outputs and period logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fltLvl_q   <= '0;
            fltCnt_q   <= '0;
            stabCnt_q  <= '0;
            state_q    <= INIT;
            prevAb_q   <= '0;
            pos_q      <= '0;
            dir_q      <= 1'b0;
            step_q     <= 1'b0;
            err_q      <= 1'b0;
            errFlag_q  <= 1'b0;
            perCnt_q   <= '0;
            period_q   <= '0;
            perVld_q   <= 1'b0;
            seenStep_q <= 1'b0;
        end else begin
            fltLvl_q   <= fltLvl_d;
            fltCnt_q   <= fltCnt_d;
            stabCnt_q  <= stabCnt_d;
            state_q    <= state_d;
            prevAb_q   <= prevAb_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            err_q      <= err_d;
            errFlag_q  <= errFlag_d;
            perCnt_q   <= perCnt_d;
            period_q   <= period_d;
            perVld_q   <= perVld_d;
            seenStep_q <= seenStep_d;
        end
    end

    assign pos        = pos_q;
    assign dir        = dir_q;
    assign step       = step_q;
    assign err        = err_q;
    assign err_flag   = errFlag_q;
    assign period     = period_q;
    assign period_vld = perVld_q;

endmodule
